out_fifo_wr_sched: RTL and testbench

OUT_FIFO_WR_SCHED -- requirements
Module: out_fifo_wr_sched

---
 rtl/out_fifo_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/out_fifo_wr_sched.sv | 148 ++++++++++++++
 tb/tb_out_fifo_wr_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/out_fifo_pkg.sv
// Shared constants and state encoding for the OUT_FIFO write scheduler.
package out_fifo_pkg;

   localparam int CH_NUM = 10;
   localparam int CH_W   = 8;
   localparam int WORD_W = CH_NUM * CH_W;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_RST_CYCLES = 8;
   localparam int DEF_CNT_W      = 16;

   typedef enum logic [1:0] {
      ST_INIT_RST    = 2'd0,
      ST_INIT_WAIT   = 2'd1,
      ST_RUN         = 2'd2,
      ST_FLUSH_DRAIN = 2'd3
   } state_t;

   // Wrapping increment of a round-robin pointer.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap, combinational, no state.
// One-hot grant, binary index and an any-request flag are produced in the same cycle.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/out_fifo_wr_sched.sv
// Schedules NUM_REQ requesters into one OUT_FIFO write port and sequences FIFO reset/flush.
// Accept in N -> registered FIFO_WREN/FIFO_D in N+1; ALMOSTFULL, FULL and flush drop all req_ready.
module out_fifo_wr_sched
   import out_fifo_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*WORD_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        fifo_full,
   input  logic                        fifo_almostfull,
   input  logic                        fifo_empty,
   input  logic                        flush,
   output logic                        FIFO_WREN,
   output logic [WORD_W-1:0]           FIFO_D,
   output logic                        FIFO_RESET,
   output logic [IDX_W-1:0]            grant_id,
   output logic [CNT_W-1:0]            wr_count,
   output logic                        busy
);

   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

   state_t               state_q, state_d;
   logic [7:0]           rst_cnt_q, rst_cnt_d;
   logic                 fifo_reset_q, fifo_reset_d;
   logic                 wren_q, wren_d;
   logic [WORD_W-1:0]    data_q, data_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     wr_count_q, wr_count_d;

   logic                 allow;
   logic                 accept;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;
   logic [WORD_W-1:0]    req_word [NUM_REQ];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_word[i] = req_data[i*WORD_W +: WORD_W];
      end
   end

   // State sequencing; allow is the only path that lets the arbiter result reach req_ready.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = '0;
      allow     = 1'b0;
      case (state_q)
         ST_INIT_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = ST_INIT_WAIT;
            end else begin
               rst_cnt_d = rst_cnt_q + 8'd1;
            end
         end
         ST_INIT_WAIT: begin
            if (fifo_empty && !fifo_full) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_FLUSH_DRAIN;
            end else begin
               allow = !fifo_full && !fifo_almostfull;
            end
         end
         ST_FLUSH_DRAIN: begin
            state_d = ST_INIT_RST;
         end
         default: begin
            state_d = ST_INIT_RST;
         end
      endcase
   end

   assign accept    = allow && arb_any;
   assign req_ready = allow ? arb_gnt : '0;

   always_comb begin
      wren_d       = accept;
      data_d       = data_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      wr_count_d   = wr_count_q;
      fifo_reset_d = (state_d == ST_INIT_RST);

      if (accept) begin
         data_d  = req_word[arb_idx];
         grant_d = arb_idx;
         ptr_d   = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
      end

      if (state_d == ST_INIT_RST && state_q != ST_INIT_RST) begin
         wr_count_d = '0;
      end else if (wren_q && wr_count_q != '1) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_INIT_RST;
         rst_cnt_q    <= '0;
         fifo_reset_q <= 1'b1;
         wren_q       <= 1'b0;
         data_q       <= '0;
         grant_q      <= '0;
         ptr_q        <= '0;
         wr_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         fifo_reset_q <= fifo_reset_d;
         wren_q       <= wren_d;
         data_q       <= data_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         wr_count_q   <= wr_count_d;
      end
   end

   assign FIFO_WREN  = wren_q;
   assign FIFO_D     = data_q;
   assign FIFO_RESET = fifo_reset_q;
   assign grant_id   = grant_q;
   assign wr_count   = wr_count_q;
   assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_out_fifo_wr_sched.sv
// Directed bench for out_fifo_wr_sched with default parameters (4 requesters, 8 reset cycles).
module tb_out_fifo_wr_sched;

   localparam int NREQ = 4;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*80-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full, fifo_almostfull, fifo_empty, flush;
   logic              FIFO_WREN;
   logic [79:0]       FIFO_D;
   logic              FIFO_RESET;
   logic [1:0]        grant_id;
   logic [15:0]       wr_count;
   logic              busy;

   logic [79:0] dat [NREQ];
   int vec_cnt = 0;
   int err_cnt = 0;
   int n;

   out_fifo_wr_sched #(
      .NUM_REQ    (4),
      .RST_CYCLES (8),
      .CNT_W      (16)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .fifo_full       (fifo_full),
      .fifo_almostfull (fifo_almostfull),
      .fifo_empty      (fifo_empty),
      .flush           (flush),
      .FIFO_WREN       (FIFO_WREN),
      .FIFO_D          (FIFO_D),
      .FIFO_RESET      (FIFO_RESET),
      .grant_id        (grant_id),
      .wr_count        (wr_count),
      .busy            (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Counts samples with FIFO_RESET high, starting from the current one.
   task automatic count_rst(output int cnt);
      cnt = 0;
      while (FIFO_RESET === 1'b1 && cnt < 50) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      dat[0] = 80'hA0A1_A2A3_A4A5_A6A7_A8A9;
      dat[1] = 80'h0123_4567_89AB_CDEF_0011;
      dat[2] = 80'hC0C1_C2C3_C4C5_C6C7_C8C9;
      dat[3] = 80'hD0D1_D2D3_D4D5_D6D7_D8D9;
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      RESET = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      fifo_almostfull = 1'b0;
      fifo_empty = 1'b1;
      flush = 1'b0;
      #3;
      chk("rst_fifo_reset", FIFO_RESET, 1);
      chk("rst_wren", FIFO_WREN, 0);
      chk("rst_d", FIFO_D, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_wrcnt", wr_count, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ready", req_ready, 0);

      @(posedge CLK);
      #1 RESET = 1'b0;
      count_rst(n);
      chk("init_rst_len", n, 8);
      chk("init_wait_busy", busy, 1);
      tick();
      chk("run_busy", busy, 0);

      // Requesters 0 and 2 alternate.
      req_valid = 4'b0101;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_ready", req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
         tick();
         chk("rr_wren", FIFO_WREN, 1);
         chk("rr_grant", grant_id, (k % 2 == 0) ? 0 : 2);
         chk("rr_d", FIFO_D, (k % 2 == 0) ? dat[0] : dat[2]);
      end
      req_valid = '0;
      tick();
      chk("rr_wrcnt", wr_count, 6);
      chk("idle_wren", FIFO_WREN, 0);
      chk("hold_d", FIFO_D, dat[2]);

      // Requester 1 alone, pointer at 3 wraps to 1.
      req_valid = 4'b0010;
      #1;
      chk("r1_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("r1_wren", FIFO_WREN, 1);
      chk("r1_d", FIFO_D, 80'h0123_4567_89AB_CDEF_0011);
      chk("r1_grant", grant_id, 1);
      tick();
      chk("r1_wren_once", FIFO_WREN, 0);
      chk("r1_wrcnt", wr_count, 7);

      // Almost-full back-pressure with everyone valid; pointer now 2.
      req_valid = 4'b1111;
      fifo_almostfull = 1'b1;
      #1;
      chk("af_ready", req_ready, 0);
      tick();
      chk("af_wren", FIFO_WREN, 0);
      chk("af_ready2", req_ready, 0);
      fifo_almostfull = 1'b0;
      #1;
      chk("af_resume", req_ready, 4'b0100);
      tick();
      chk("af_grant", grant_id, 2);
      chk("af_next_ready", req_ready, 4'b1000);
      req_valid = '0;
      tick();
      chk("drop_wren", FIFO_WREN, 0);

      // Full blocks accepts without leaving RUN; pointer now 3.
      req_valid = 4'b0001;
      fifo_full = 1'b1;
      #1;
      chk("full_ready", req_ready, 0);
      tick();
      chk("full_wren", FIFO_WREN, 0);
      chk("full_busy", busy, 0);
      fifo_full = 1'b0;

      // Accept 0, then flush alongside a valid request.
      #1;
      chk("pre_flush_ready", req_ready, 4'b0001);
      tick();
      flush = 1'b1;
      #1;
      chk("flush_ready", req_ready, 0);
      chk("flush_prior_wren", FIFO_WREN, 1);
      chk("flush_prior_d", FIFO_D, dat[0]);
      tick();
      flush = 1'b0;
      req_valid = '0;
      chk("drain_busy", busy, 1);
      chk("drain_fifo_reset", FIFO_RESET, 0);
      chk("drain_wren", FIFO_WREN, 0);
      tick();
      chk("flush_wrcnt", wr_count, 0);
      count_rst(n);
      chk("flush_rst_len", n, 8);
      tick();
      chk("flush_run", busy, 0);

      // Reset lands while a write is in flight; pointer now 1 so 0 wins after wrap.
      req_valid = 4'b0001;
      #1;
      chk("pre_rst_ready", req_ready, 4'b0001);
      tick();
      chk("pre_rst_wren", FIFO_WREN, 1);
      #2 RESET = 1'b1;
      #1;
      chk("arst_wren", FIFO_WREN, 0);
      chk("arst_fifo_reset", FIFO_RESET, 1);
      chk("arst_d", FIFO_D, 0);
      chk("arst_wrcnt", wr_count, 0);
      chk("arst_busy", busy, 1);
      chk("arst_ready", req_ready, 0);
      req_valid = '0;
      @(posedge CLK);
      #1 RESET = 1'b0;
      count_rst(n);
      chk("rerst_len", n, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
